// File: rtl/tm1638_responder.sv
// Chip-side model of a TM1638 LED/key controller: decodes STB/CLK/DIO frames into display RAM
// and display control, and shifts key-scan bytes back out. Define TM1638_RESPONDER_SYNC_EN for 2-flop pin synchronizers.
module tm1638_responder #(
    parameter int RAM_AW    = 4,
    parameter int KEY_BYTES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tm_stb,
    input  logic                   tm_clk,
    input  logic                   tm_dio_in,
    output logic                   tm_dio_out,
    output logic                   tm_dio_oe,
    input  logic [8*KEY_BYTES-1:0] keys,
    input  logic [RAM_AW-1:0]      ram_raddr,
    output logic [7:0]             ram_rdata,
    output logic                   ram_we,
    output logic                   display_on,
    output logic [2:0]             brightness,
    output logic                   proto_error
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_READ,
        S_DROP
    } state_t;

    state_t state_q, state_d;

    logic stb_s, clk_s, dio_s;
    logic stb_q, clk_q;
    logic stb_rise, stb_fall, clk_rise;
    logic bit_ok, byte_done;

    logic [2:0]             bit_cnt;
    logic [7:0]             shift_in;
    logic [7:0]             rx_byte;
    logic [RAM_AW-1:0]      addr_q;
    logic                   fixed_addr;
    logic [8*KEY_BYTES-1:0] key_sr;
    logic                   wr_en;
    logic [7:0]             ram [RAM_DEPTH];

`ifdef TM1638_RESPONDER_SYNC_EN
    // Bit order in the sync vectors: [2]=dio, [1]=clk, [0]=stb; idle-high lines reset high.
    logic [2:0] sync1, sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 3'b011;
            sync2 <= 3'b011;
        end else begin
            sync1 <= {tm_dio_in, tm_clk, tm_stb};
            sync2 <= sync1;
        end
    end

    assign {dio_s, clk_s, stb_s} = sync2;
`else
    assign stb_s = tm_stb;
    assign clk_s = tm_clk;
    assign dio_s = tm_dio_in;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            stb_q <= 1'b1;
            clk_q <= 1'b1;
        end else begin
            stb_q <= stb_s;
            clk_q <= clk_s;
        end
    end

    assign stb_rise = stb_s & ~stb_q;
    assign stb_fall = ~stb_s & stb_q;
    assign clk_rise = clk_s & ~clk_q;

    // A simultaneous STB rise leaves stb_s high, so that bit is dropped here.
    assign bit_ok    = clk_rise & ~stb_s & (state_q != S_IDLE);
    assign byte_done = bit_ok & (bit_cnt == 3'd7);
    assign rx_byte   = {dio_s, shift_in[7:1]};
    assign wr_en     = byte_done & (state_q == S_DATA);

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the default assignment up front keeps this combinational block free of latches.
    always_comb begin
        state_d = state_q;
        if (stb_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (stb_fall) state_d = S_CMD;
                S_CMD: begin
                    if (byte_done) begin
                        case (rx_byte[7:6])
                            2'b01:   state_d = rx_byte[1] ? S_READ : S_DATA;
                            2'b11:   state_d = S_DATA;
                            default: state_d = S_DROP;
                        endcase
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        tm_dio_oe  = 1'b0;
        tm_dio_out = 1'b0;
        if (state_q == S_READ) begin
            tm_dio_oe  = 1'b1;
            tm_dio_out = key_sr[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            addr_q      <= '0;
            fixed_addr  <= 1'b0;
            key_sr      <= '0;
            ram_we      <= 1'b0;
            display_on  <= 1'b0;
            brightness  <= '0;
            proto_error <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (stb_rise) begin
                if (bit_cnt != 3'd0) proto_error <= 1'b1;
                bit_cnt <= '0;
            end else if (stb_fall) begin
                bit_cnt <= '0;
            end else if (bit_ok) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= rx_byte;
            end

            if (byte_done && state_q == S_CMD) begin
                case (rx_byte[7:6])
                    2'b01: begin
                        if (rx_byte[1]) key_sr     <= keys;
                        else            fixed_addr <= rx_byte[2];
                    end
                    2'b11: addr_q <= rx_byte[RAM_AW-1:0];
                    2'b10: begin
                        display_on <= rx_byte[3];
                        brightness <= rx_byte[2:0];
                    end
                    default: ;
                endcase
            end

            if (wr_en) begin
                ram_we <= 1'b1;
                if (!fixed_addr) addr_q <= addr_q + 1'b1;
            end

            if (bit_ok && state_q == S_READ) key_sr <= key_sr >> 1;
        end
    end

    // NOTE: the RAM must clear on reset, so it is a flop array rather than an inferred block RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (wr_en) ram[addr_q] <= rx_byte;
            ram_rdata <= ram[ram_raddr];
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a bit-banged master drives frames, and expected values
// come from hand-decoded command sequences.
module tb_tm1638_responder;

    localparam int RAM_AW    = 4;
    localparam int KEY_BYTES = 4;
`ifdef TM1638_RESPONDER_SYNC_EN
    localparam int OE_LAT = 3;
`else
    localparam int OE_LAT = 1;
`endif

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   tm_stb, tm_clk, tm_dio_in;
    logic                   tm_dio_out, tm_dio_oe;
    logic [8*KEY_BYTES-1:0] keys;
    logic [RAM_AW-1:0]      ram_raddr;
    logic [7:0]             ram_rdata;
    logic                   ram_we;
    logic                   display_on;
    logic [2:0]             brightness;
    logic                   proto_error;

    int n_cmp   = 0;
    int n_bad   = 0;
    int we_total = 0;
    int we_base;
    logic [31:0] rd;

    always #5 clock = ~clock;

    tm1638_responder #(.RAM_AW(RAM_AW), .KEY_BYTES(KEY_BYTES)) dut (
        .clock      (clock),
        .reset      (reset),
        .tm_stb     (tm_stb),
        .tm_clk     (tm_clk),
        .tm_dio_in  (tm_dio_in),
        .tm_dio_out (tm_dio_out),
        .tm_dio_oe  (tm_dio_oe),
        .keys       (keys),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .ram_we     (ram_we),
        .display_on (display_on),
        .brightness (brightness),
        .proto_error(proto_error)
    );

    always @(posedge clock) if (ram_we) we_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        tm_clk    = 1'b0;
        tm_dio_in = b;
        wait_cyc(4);
        tm_clk = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        tm_stb = 1'b0;
        wait_cyc(4);
        if (n > 0) send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        if (n > 3) send_byte(b3);
        tm_stb = 1'b1;
        wait_cyc(4);
    endtask

    task automatic check_ram(input string tag, input logic [RAM_AW-1:0] a, input logic [7:0] exp);
        ram_raddr = a;
        wait_cyc(1);
        check(tag, ram_rdata, exp);
    endtask

    initial begin
        reset     = 1'b1;
        tm_stb    = 1'b1;
        tm_clk    = 1'b1;
        tm_dio_in = 1'b0;
        keys      = '0;
        ram_raddr = '0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);

        check("rst_oe", tm_dio_oe, 0);
        check("rst_dout", tm_dio_out, 0);
        check("rst_we", ram_we, 0);
        check("rst_disp", {display_on, brightness}, 0);
        check("rst_perr", proto_error, 0);
        check_ram("rst_ram0", 4'd0, 8'h00);

        // auto-increment burst from address 0
        send_frame(1, 8'h40, 8'h00, 8'h00, 8'h00);
        we_base = we_total;
        send_frame(4, 8'hC0, 8'h11, 8'h22, 8'h33);
        check("auto_we", we_total - we_base, 3);
        check_ram("auto_ram0", 4'd0, 8'h11);
        check_ram("auto_ram1", 4'd1, 8'h22);
        check_ram("auto_ram2", 4'd2, 8'h33);
        // data command followed by data: lands on the persisted address 3
        we_base = we_total;
        send_frame(2, 8'h40, 8'h5A, 8'h00, 8'h00);
        check("persist_we", we_total - we_base, 1);
        check_ram("persist_ram3", 4'd3, 8'h5A);

        // fixed-address mode
        send_frame(1, 8'h44, 8'h00, 8'h00, 8'h00);
        we_base = we_total;
        send_frame(3, 8'hC5, 8'hAA, 8'hBB, 8'h00);
        check("fixed_we", we_total - we_base, 2);
        check_ram("fixed_ram5", 4'd5, 8'hBB);
        check_ram("fixed_ram6", 4'd6, 8'h00);

        // address wrap 15 -> 0
        send_frame(1, 8'h40, 8'h00, 8'h00, 8'h00);
        send_frame(3, 8'hCF, 8'h01, 8'h02, 8'h00);
        check_ram("wrap_ram15", 4'd15, 8'h01);
        check_ram("wrap_ram0", 4'd0, 8'h02);

        // key-scan read
        keys   = 32'h8001_F00D;
        tm_stb = 1'b0;
        wait_cyc(4);
        send_byte(8'h42);
        check("read_oe_on", tm_dio_oe, 1);
        for (int k = 0; k < 32; k++) begin
            tm_clk    = 1'b0;
            tm_dio_in = 1'b0;
            wait_cyc(4);
            rd[k]  = tm_dio_out;
            tm_clk = 1'b1;
            wait_cyc(4);
        end
        check("read_b0", rd[7:0], 8'h0D);
        check("read_b1", rd[15:8], 8'hF0);
        check("read_b2", rd[23:16], 8'h01);
        check("read_b3", rd[31:24], 8'h80);
        check("read_bit33", tm_dio_out, 0);
        check("read_oe_tail", tm_dio_oe, 1);
        tm_stb = 1'b1;
        wait_cyc(OE_LAT - 1);
        check("read_oe_hold", tm_dio_oe, 1);
        wait_cyc(1);
        check("read_oe_off", tm_dio_oe, 0);
        check("read_perr", proto_error, 0);
        wait_cyc(4);

        // display control
        send_frame(1, 8'h8C, 8'h00, 8'h00, 8'h00);
        check("disp_on", display_on, 1);
        check("disp_bright", brightness, 4);

        // STB rising after 5 bits of a data byte
        we_base = we_total;
        tm_stb  = 1'b0;
        wait_cyc(4);
        send_byte(8'hC0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        tm_stb = 1'b1;
        wait_cyc(4);
        check("perr_set", proto_error, 1);
        check("perr_we", we_total - we_base, 0);
        check_ram("perr_ram0", 4'd0, 8'h02);
        we_base = we_total;
        send_frame(2, 8'hC1, 8'h77, 8'h00, 8'h00);
        check("perr_next_we", we_total - we_base, 1);
        check_ram("perr_next_ram1", 4'd1, 8'h77);
        check("perr_sticky", proto_error, 1);

        // reset in the middle of a data byte
        tm_stb = 1'b0;
        wait_cyc(4);
        send_byte(8'hC2);
        send_byte(8'h99);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        we_base = we_total;
        reset   = 1'b1;
        tm_stb  = 1'b1;
        tm_clk  = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        check("mrst_we", we_total - we_base, 0);
        check("mrst_oe", tm_dio_oe, 0);
        check("mrst_disp", {display_on, brightness}, 0);
        check("mrst_perr", proto_error, 0);
        check_ram("mrst_ram0", 4'd0, 8'h00);
        check_ram("mrst_ram1", 4'd1, 8'h00);
        check_ram("mrst_ram2", 4'd2, 8'h00);
        check_ram("mrst_ram15", 4'd15, 8'h00);
        send_frame(2, 8'hC3, 8'h3C, 8'h00, 8'h00);
        check_ram("mrst_after_ram3", 4'd3, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
